// File: rtl/sobel_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for sobel_window_buffer.
interface sobel_window_buffer_if;
   logic        start;
   logic        pix_valid;
   logic [31:0] read_word;
   logic        pix_ready;
   logic [71:0] win;
   logic        win_valid;
   logic        win_ready;
   logic [15:0] win_row;
   logic [15:0] win_col;
   logic        frame_done;

   modport master (
      output start, pix_valid, read_word, win_ready,
      input  pix_ready, win, win_valid, win_row, win_col, frame_done
   );

   modport slave (
      input  start, pix_valid, read_word, win_ready,
      output pix_ready, win, win_valid, win_row, win_col, frame_done
   );
endinterface

// File: rtl/sobel_window_buffer.sv
// Grayscale conversion, two line buffers and a 3x3 shift window feeding
// the Sobel stage with one neighbourhood per interior pixel.
//
// state | meaning
// IDLE  | waiting for start, no pixels accepted
// RUN   | accepting pixels, emitting windows
// DRAIN | last pixel taken, waiting for the final window to be consumed
// DONE  | frame complete, frame_done held until start
module sobel_window_buffer #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input logic                  clk,
   input logic                  rst,
   sobel_window_buffer_if.slave io
);
   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state, state_next;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [7:0]    line0 [IMG_WIDTH];
   logic [7:0]    line1 [IMG_WIDTH];
   logic [23:0]   sh0, sh1;
   logic [9:0]    gray_sum;
   logic [7:0]    gray;
   logic [23:0]   new_col;
   logic          accept, consume, last_col, last_row, win_hit;

   // The +2 rounds to nearest; the 10-bit sum never exceeds 1022 so no saturation.
   assign gray_sum = {2'b00, io.read_word[23:16]} + {1'b0, io.read_word[15:8], 1'b0}
                   + {2'b00, io.read_word[7:0]} + 10'd2;
   assign gray     = gray_sum[9:2];
   assign new_col  = {gray, line1[col], line0[col]};

   assign io.pix_ready  = (state == RUN) && !io.start && (!io.win_valid || io.win_ready);
   assign io.frame_done = (state == DONE);
   assign accept        = io.pix_valid && io.pix_ready;
   assign consume       = io.win_valid && io.win_ready;
   assign last_col      = (col == CW'(IMG_WIDTH - 1));
   assign last_row      = (row == RW'(IMG_HEIGHT - 1));
   assign win_hit       = (row >= RW'(2)) && (col >= CW'(2));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode; start restarts the frame from any state.
   always_comb begin
      state_next = state;
      if (io.start) begin
         state_next = RUN;
      end else begin
         case (state)
            RUN:     if (accept && last_col && last_row) state_next = DRAIN;
            DRAIN:   if (consume) state_next = DONE;
            default: state_next = state;
         endcase
      end
   end

   // Line buffers and the two trailing window columns; contents need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         line0[col] <= line1[col];
         line1[col] <= gray;
         sh0        <= sh1;
         sh1        <= new_col;
      end
   end

   // Raster counters and the registered output window.
   always_ff @(posedge clk) begin
      if (rst) begin
         row       <= '0;
         col       <= '0;
         win_valid_clear();
         io.win     <= '0;
         io.win_row <= '0;
         io.win_col <= '0;
      end else if (io.start) begin
         row          <= '0;
         col          <= '0;
         io.win_valid <= 1'b0;
      end else begin
         if (accept) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
            if (win_hit) begin
               io.win     <= {new_col[23:16], sh1[23:16], sh0[23:16],
                              new_col[15:8],  sh1[15:8],  sh0[15:8],
                              new_col[7:0],   sh1[7:0],   sh0[7:0]};
               io.win_row <= 16'(row) - 16'd1;
               io.win_col <= 16'(col) - 16'd1;
            end
         end
         if (accept && win_hit) io.win_valid <= 1'b1;
         else if (consume)      io.win_valid <= 1'b0;
      end
   end

   task automatic win_valid_clear();
      io.win_valid <= 1'b0;
   endtask
endmodule

// File: doc/sobel_window_buffer.md
Name: sobel_window_buffer

Overview:
Upstream stage of sobel_edge_detection. Accepts a raster stream of 24-bit BGR pixel words and converts each to 8-bit grayscale. Keeps two line buffers and a 3x3 shift window. Emits one 3x3 grayscale neighbourhood per interior pixel, with a valid/ready handshake on both sides.

Parameters:
IMG_WIDTH, 640, pixels per row (>=3); sizes both line buffers and the column counter.
IMG_HEIGHT, 480, rows per frame (>=3); sizes the row counter.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a new frame
pix_valid  in  1  read_word holds a pixel
read_word  in  32  pixel word: [7:0]=B, [15:8]=G, [23:16]=R, [31:24] ignored
pix_ready  out  1  pixel accepted this cycle when pix_valid && pix_ready
win  out  72  3x3 window; byte at win[8*(3*r+c) +: 8], r=0 top/oldest row, c=0 leftmost/oldest column; centre is win[39:32]
win_valid  out  1  win/win_row/win_col valid
win_ready  in  1  downstream consumes the window when win_valid && win_ready
win_row  out  16  image row of the window centre
win_col  out  16  image column of the window centre
frame_done  out  1  high after the final window of the frame is consumed; held until start/rst

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. pix_ready, win_valid and frame_done are 0. win, win_row and win_col are 0. Row/column counters are 0. Line-buffer contents are don't-care.
- Grayscale conversion: gray = (R + 2*G + B + 2) >> 2, computed in 10 bits. The result is always 0..255, so there is no saturation. Conversion is combinational on read_word, before storage.
- State machine:
  - IDLE: pix_ready=0. start -> RUN.
  - RUN: pix_ready = !start && (!win_valid || win_ready). The last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1) is accepted -> DRAIN.
  - DRAIN: pix_ready=0. Last window consumed (win_valid && win_ready) -> DONE, and frame_done=1 on the next cycle.
  - DONE: pix_ready=0, frame_done=1. start -> RUN.
- start in any state: clears counters, win_valid and frame_done on the next edge, then enters RUN. A pixel presented in the same cycle as start is not accepted. start has priority over a simultaneous consume; the pending window is dropped.
- On each accepted pixel at (row, col):
  - shift the gray value into column 2 of the window;
  - shift the line-buffer column at address col up one row (new pixel -> line1[col], old line1[col] -> line0[col]);
  - advance col; at IMG_WIDTH-1, col wraps to 0 and row increments.
- Window generation: if row>=2 and col>=2 when a pixel is accepted, the next edge loads win with rows {line0, line1, new}[col-2..col]. On the same edge, win_valid=1, win_row=row-1, win_col=col-1.
- Latency: exactly one cycle from pixel acceptance to win_valid.
- Windows are never emitted across a row wrap. The shift window is refilled at col 0 and 1 of each row.
- Each frame yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows, in raster order of their centres.
- Output hold: while win_valid && !win_ready, win, win_row and win_col hold stable and pix_ready=0.
- Consume with no new window: win_valid falls on the next edge.
- Consume and new pixel accepted in the same cycle: back-to-back windows, 1 per cycle sustained.
- rst mid-frame: returns to IDLE. Any pending window is discarded and no frame_done is produced.

Test Plan (IMG_WIDTH=5, IMG_HEIGHT=4):
- Reset state: assert rst 2 cycles with pix_valid=1 -> pix_ready=0, win_valid=0, frame_done=0; no acceptance until start.
- Conversion: read_word=32'hFF_10_20_30 (R=0x10, G=0x20, B=0x30) -> gray=(16+64+48+2)>>2=0x20. Also 32'h00FFFFFF -> 0xFF.
- Full frame: start, then 20 pixels with gray value = 10*row+col, win_ready=1 -> exactly 6 windows.
  - Centres in order: (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
  - Window for centre (1,1): win bytes 0,1,2,10,11,12,20,21,22 in order r0c0..r2c2.
  - Each window appears 1 cycle after pixel (2,2),(2,3),(2,4),(3,2),... is accepted.
  - frame_done rises 1 cycle after the 6th window is consumed.
- Back-pressure: hold win_ready=0 for 5 cycles on the window centred at (1,2) -> win stable; pix_ready=0; no pixel is lost. Window order and contents match the full-frame case.
- Back-to-back: pix_valid=1 and win_ready=1 continuously -> within each row, windows appear on consecutive cycles with no bubbles.
- Restart / abort:
  - start while in DONE -> frame_done clears next cycle and a second identical frame gives identical windows.
  - rst after 12 pixels -> IDLE, win_valid=0; a subsequent start plus a full frame gives the correct 6 windows.
